// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill over a request/beat memory port.
// Optional hit/miss statistics counters are built in when ICACHE_STATS_EN is defined.
module icache_dm #(
    parameter int unsigned LINES      = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ic_req_valid_i,
    input  logic [31:0] ic_req_addr_i,
    input  logic        kill_i,
    input  logic        inv_i,
    output logic        ic_rsp_valid_o,
    output logic [31:0] ic_rsp_data_o,
    output logic        busy_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = 2 + WSEL_W;
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
    localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_RSP
    } state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic               inv_pend_q, inv_pend_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic [IDX_W-1:0]   req_idx_q, req_idx_d;
    logic [WSEL_W-1:0]  beat_q, beat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES*LINE_WORDS];

    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   lk_idx;
    logic [WSEL_W-1:0]  lk_word;
    logic               lk_hit;
    logic [31:0]        lk_data;
    logic               lookup_hit;
    logic               lookup_miss;
    logic               fill_we;
    logic               fill_last;
    logic [1:0]         unused_addr_lsb;

    assign lk_word         = ic_req_addr_i[OFF_W-1:2];
    assign lk_idx          = ic_req_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign lk_tag          = ic_req_addr_i[31:OFF_W+IDX_W];
    assign unused_addr_lsb = ic_req_addr_i[1:0];

    // A lookup coinciding with an invalidate must miss, since the line is about to be dropped.
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !inv_i;
    assign lk_data = data_q[{lk_idx, lk_word}];

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        inv_pend_d  = inv_pend_q;
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        beat_d      = beat_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        lookup_hit  = 1'b0;
        lookup_miss = 1'b0;
        fill_we     = 1'b0;
        fill_last   = 1'b0;

        case (state_q)
            IDLE: begin
                if (inv_i) begin
                    valid_d = '0;
                end
                if (ic_req_valid_i) begin
                    if (lk_hit) begin
                        lookup_hit  = 1'b1;
                        rsp_valid_d = !kill_i;
                        rsp_data_d  = lk_data;
                    end else begin
                        lookup_miss = 1'b1;
                        state_d     = MEM_REQ;
                        req_tag_d   = lk_tag;
                        req_idx_d   = lk_idx;
                    end
                end
            end
            MEM_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = MEM_RSP;
                    beat_d  = '0;
                end
            end
            MEM_RSP: begin
                if (mem_rsp_valid_i) begin
                    fill_we = 1'b1;
                    beat_d  = beat_q + WSEL_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        fill_last = 1'b1;
                        state_d   = IDLE;
                        if (inv_pend_q || inv_i) begin
                            valid_d = '0;
                        end else begin
                            valid_d[req_idx_q] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && inv_i) begin
            inv_pend_d = 1'b1;
        end
        if (fill_last) begin
            inv_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            inv_pend_q  <= 1'b0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            inv_pend_q  <= inv_pend_d;
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            data_q[{req_idx_q, beat_q}] <= mem_rsp_data_i;
            if (fill_last) begin
                tag_q[req_idx_q] <= req_tag_q;
            end
        end
    end

    assign ic_rsp_valid_o  = rsp_valid_q;
    assign ic_rsp_data_o   = rsp_data_q;
    assign busy_o          = (state_q != IDLE);
    assign mem_req_valid_o = (state_q == MEM_REQ);
    assign mem_req_addr_o  = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup_hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (lookup_miss) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetches checked
// against an array-based model of cache contents and a deterministic backing memory.
module tb_icache_dm;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        kill;
    logic        inv;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        mem_req_valid;
    logic        mreq_ready;
    logic [31:0] mem_req_addr;
    logic        mrsp_valid;
    logic [31:0] mrsp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks;
    int errors;
    int hits;
    int misses;

    logic        mv    [64];
    logic [31:0] mline [64];
    logic [31:0] mdat  [64][4];

    icache_dm #(.LINES(64), .LINE_WORDS(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ic_req_valid_i  (req_valid),
        .ic_req_addr_i   (req_addr),
        .kill_i          (kill),
        .inv_i           (inv),
        .ic_rsp_valid_o  (rsp_valid),
        .ic_rsp_data_o   (rsp_data),
        .busy_o          (busy),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mreq_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mrsp_valid),
        .mem_rsp_data_i  (mrsp_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o       (hit_cnt),
        .miss_cnt_o      (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] memw(input logic [31:0] line, input int unsigned w);
        if (line == 32'h100) return 32'hA0 + w;
        return (line * 32'h0001_9E37) ^ (w << 28) ^ 32'h5EED_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    task automatic chk_stats();
`ifdef ICACHE_STATS_EN
        chk("hit_cnt", hit_cnt, hits);
        chk("miss_cnt", miss_cnt, misses);
`endif
    endtask

    task automatic idle_chk(input logic [31:0] exp_data);
        req_valid = 1'b0;
        cyc();
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_rsp_hold", rsp_data, exp_data);
    endtask

    task automatic refill(input logic [31:0] line, input int unsigned rdy_dly, input int inv_beat);
        mreq_ready = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            cyc();
            chk("bp_req_valid", mem_req_valid, 1);
            chk("bp_req_addr", mem_req_addr, line);
            chk("bp_busy", busy, 1);
            chk("bp_rsp_valid", rsp_valid, 0);
        end
        mreq_ready = 1'b1;
        cyc();
        mreq_ready = 1'b0;
        chk("hs_req_drop", mem_req_valid, 0);
        chk("hs_busy", busy, 1);
        for (int b = 0; b < 4; b++) begin
            int unsigned gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cyc();
                chk("gap_busy", busy, 1);
                chk("gap_rsp_valid", rsp_valid, 0);
            end
            mrsp_valid = 1'b1;
            mrsp_data  = memw(line, b);
            inv        = (b == inv_beat);
            cyc();
            mrsp_valid = 1'b0;
            inv        = 1'b0;
        end
        chk("refill_done_busy", busy, 0);
        chk("refill_done_rsp", rsp_valid, 0);
        chk("refill_done_req", mem_req_valid, 0);
    endtask

    // Presents addr until it is served; misses trigger refills and a re-presented lookup.
    task automatic fetch(input logic [31:0] addr, input int unsigned rdy_dly, input int inv_beat,
                         input bit kill_hit, input bit inv_first);
        logic [31:0] line;
        int unsigned idx;
        int unsigned w;
        int          inv_b;
        bit          done;
        line  = addr & 32'hFFFF_FFF0;
        idx   = (addr >> 4) % 64;
        w     = (addr >> 2) % 4;
        inv_b = inv_beat;
        done  = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int att = 0; att < 4 && !done; att++) begin
            bit h;
            h    = mv[idx] && (mline[idx] == line) && !inv_first;
            kill = h && kill_hit;
            inv  = inv_first;
            cyc();
            kill = 1'b0;
            inv  = 1'b0;
            if (inv_first) begin
                model_clear();
                inv_first = 1'b0;
            end
            if (h) begin
                hits++;
                chk("hit_rsp_valid", rsp_valid, kill_hit ? 0 : 1);
                if (!kill_hit) chk("hit_rsp_data", rsp_data, mdat[idx][w]);
                chk("hit_no_mem", mem_req_valid, 0);
                chk("hit_busy", busy, 0);
                done = 1'b1;
            end else begin
                misses++;
                chk("miss_rsp_valid", rsp_valid, 0);
                chk("miss_busy", busy, 1);
                chk("miss_req_valid", mem_req_valid, 1);
                chk("miss_req_addr", mem_req_addr, line);
                refill(line, rdy_dly, inv_b);
                if (inv_b >= 0) begin
                    model_clear();
                end else begin
                    mv[idx]    = 1'b1;
                    mline[idx] = line;
                    for (int k = 0; k < 4; k++) mdat[idx][k] = memw(line, k);
                end
                inv_b = -1;
            end
        end
    endtask

    initial begin
        logic [31:0] pool [8];
        checks = 0;
        errors = 0;
        hits   = 0;
        misses = 0;
        model_clear();
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        kill       = 1'b0;
        inv        = 1'b0;
        mreq_ready = 1'b0;
        mrsp_valid = 1'b0;
        mrsp_data  = '0;

        #2 rst_n = 1'b0;
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk_stats();
        cyc();
        cyc();
        rst_n = 1'b1;

        // Cold miss, then sequential hits in the same line
        fetch(32'h100, 0, -1, 0, 0);
        chk("cold_rsp_data", rsp_data, 32'hA0);
        fetch(32'h104, 0, -1, 0, 0);
        fetch(32'h108, 0, -1, 0, 0);
        fetch(32'h10C, 0, -1, 0, 0);
        chk("seq_last_data", rsp_data, 32'hA3);
        idle_chk(32'hA3);
        chk_stats();

        // Conflict on index 16
        fetch(32'h500, 1, -1, 0, 0);
        fetch(32'h100, 0, -1, 0, 0);
        chk("conflict_refill_data", rsp_data, 32'hA0);

        // Backpressure of 5 cycles
        fetch(32'h2040, 5, -1, 0, 0);
        fetch(32'h2044, 0, -1, 0, 0);

        // Kill on a hit, then normal hit
        fetch(32'h2044, 0, -1, 1, 0);
        fetch(32'h2048, 0, -1, 0, 0);

        // Invalidate during MEM_RSP: refilled line must not become valid
        fetch(32'h3000, 0, 1, 0, 0);
        fetch(32'h100, 0, -1, 0, 0);
        // Invalidate in IDLE, and request coinciding with invalidate
        req_valid = 1'b0;
        inv       = 1'b1;
        cyc();
        inv = 1'b0;
        model_clear();
        fetch(32'h3004, 0, -1, 0, 0);
        fetch(32'h3008, 0, -1, 0, 1);
        chk_stats();

        // Reset in the middle of a refill
        req_valid = 1'b1;
        req_addr  = 32'h600;
        cyc();
        misses++;
        chk("mid_miss_req", mem_req_valid, 1);
        mreq_ready = 1'b1;
        cyc();
        mreq_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mrsp_valid = 1'b1;
            mrsp_data  = 32'hDEAD_0000 + b;
            cyc();
        end
        mrsp_data = 32'hDEAD_0002;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_req_valid", mem_req_valid, 0);
        chk("arst_req_addr", mem_req_addr, 0);
        model_clear();
        hits   = 0;
        misses = 0;
        chk_stats();
        req_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("stray_beat_busy", busy, 0);
        chk("stray_beat_req", mem_req_valid, 0);
        mrsp_valid = 1'b0;
        fetch(32'h100, 0, -1, 0, 0);
        chk("post_rst_data", rsp_data, 32'hA0);
        chk_stats();

        // Randomized fetches over a small set of lines with aliasing indices
        pool[0] = 32'h0000_0100;
        pool[1] = 32'h0000_0500;
        pool[2] = 32'h0000_0900;
        pool[3] = 32'h0000_1240;
        pool[4] = 32'h0000_2040;
        pool[5] = 32'h0000_3000;
        pool[6] = 32'h0000_7FF0;
        pool[7] = 32'hFFFF_FFC0;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          ib;
            a  = pool[$urandom_range(0, 7)] + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            ib = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(a, $urandom_range(0, 3), ib, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                cyc();
                chk("rand_idle_rsp", rsp_valid, 0);
            end
        end
        chk_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
